// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line sequencer: feeds one 40-bit command frame to the sd_cmd_if serializer,
// waits for the response or NCR timeout, checks it and retries transient errors.
module sd_cmd_ctrl #(
  parameter int DELAY_W   = 6,
  parameter int NCC_DELAY = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [5:0]         cmd_index,
  input  logic [31:0]        cmd_arg,
  input  logic [1:0]         cmd_resp_type,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [47:0]        resp_data,
  output logic [3:0]         resp_status,
  output logic [1:0]         resp_retries,
  output logic               write_strb,
  output logic               write_no_crc_sig,
  output logic [7:0]         write_bits,
  output logic [DELAY_W-1:0] write_delay,
  output logic [31:0]        data_towrite,
  input  logic               write_data_ack,
  input  logic               more_data_towrite,
  input  logic               read_ready,
  input  logic               read_crc_err,
  input  logic [47:0]        data_read,
  input  logic               ncr_timeout
);

  localparam int RC_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] RT_NONE = 2'b00;
  localparam logic [1:0] RT_R3   = 2'b10;
  localparam logic [1:0] RT_R2   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SEND0, S_SEND1, S_WAIT, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_index;
  logic [31:0]       r_arg;
  logic [1:0]        r_type;
  logic [RC_W-1:0]   r_retry_left;
  logic [1:0]        r_attempts;
  logic [31:0]       r_data_towrite;
  logic [47:0]       r_resp_data;
  logic [3:0]        r_resp_status;

  logic              w_accept, w_retry, w_finish, w_load_word1;
  logic              w_idx_err, w_crc_err, w_timeout;
  logic [47:0]       w_fin_data;
  logic [5:0]        w_exp_index;
  logic [31:0]       w_word0;

  assign w_exp_index = (r_type == RT_R3) ? 6'h3F : r_index;
  assign w_word0     = {2'b01, r_index, r_arg[31:8]};

  // NOTE: synchronous active-low reset; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_retry      = 1'b0;
    w_finish     = 1'b0;
    w_load_word1 = 1'b0;
    w_idx_err    = 1'b0;
    w_crc_err    = 1'b0;
    w_timeout    = 1'b0;
    w_fin_data   = '0;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = (cmd_resp_type == RT_R2) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_SEND0;
      S_SEND0: if (write_data_ack) begin
        w_load_word1 = 1'b1;
        w_state_nxt  = S_SEND1;
      end
      S_SEND1: if (write_data_ack && !more_data_towrite) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_type == RT_NONE) begin
          // Only the timeout ends a no-response command: it proves NCC idle on the line.
          if (ncr_timeout) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (read_ready || ncr_timeout) begin
          if (read_ready) begin
            w_fin_data = data_read;
            w_crc_err  = (r_type != RT_R3) && read_crc_err;
            w_idx_err  = (data_read[47:46] != 2'b00) || (data_read[45:40] != w_exp_index) ||
                         ((r_type == RT_R3) && !data_read[0]);
          end else begin
            w_timeout = 1'b1;
          end
          if ((w_crc_err || w_timeout) && !w_idx_err && (r_retry_left != '0)) begin
            w_retry     = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_index        <= '0;
      r_arg          <= '0;
      r_type         <= '0;
      r_retry_left   <= '0;
      r_attempts     <= '0;
      r_data_towrite <= '0;
      r_resp_data    <= '0;
      r_resp_status  <= '0;
    end else begin
      if (w_accept) begin
        r_index       <= cmd_index;
        r_arg         <= cmd_arg;
        r_type        <= cmd_resp_type;
        r_retry_left  <= RC_W'(MAX_RETRY);
        r_attempts    <= '0;
        r_resp_data   <= '0;
        r_resp_status <= (cmd_resp_type == RT_R2) ? 4'b1000 : 4'b0000;
        if (cmd_resp_type != RT_R2) r_data_towrite <= {2'b01, cmd_index, cmd_arg[31:8]};
      end
      if (w_retry) begin
        r_retry_left   <= r_retry_left - 1'b1;
        r_data_towrite <= w_word0;
        if (r_attempts != 2'b11) r_attempts <= r_attempts + 1'b1;
      end
      if (w_load_word1) r_data_towrite <= {r_arg[7:0], 24'h0};
      if (w_finish) begin
        r_resp_data   <= w_fin_data;
        r_resp_status <= {1'b0, w_idx_err, w_crc_err, w_timeout};
      end
    end
  end

  assign cmd_ready        = (r_state == S_IDLE);
  assign resp_valid       = (r_state == S_DONE);
  assign write_strb       = (r_state == S_ISSUE);
  assign write_no_crc_sig = 1'b0;
  assign write_bits       = 8'd40;
  assign write_delay      = DELAY_W'(NCC_DELAY);
  assign data_towrite     = r_data_towrite;
  assign resp_data        = r_resp_data;
  assign resp_status      = r_resp_status;
  assign resp_retries     = r_attempts;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Bench for sd_cmd_ctrl: directed vector table, reset-mid-command sequence and
// randomized commands scored against an attempt-by-attempt reference model.
module tb_sd_cmd_ctrl;

  localparam int DELAY_W   = 6;
  localparam int NCC_DELAY = 8;
  localparam int MAX_RETRY = 2;

  logic               clk = 1'b0;
  logic               resetn;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [5:0]         cmd_index;
  logic [31:0]        cmd_arg;
  logic [1:0]         cmd_resp_type;
  logic               resp_valid;
  logic               resp_ready;
  logic [47:0]        resp_data;
  logic [3:0]         resp_status;
  logic [1:0]         resp_retries;
  logic               write_strb;
  logic               write_no_crc_sig;
  logic [7:0]         write_bits;
  logic [DELAY_W-1:0] write_delay;
  logic [31:0]        data_towrite;
  logic               write_data_ack;
  logic               more_data_towrite;
  logic               read_ready;
  logic               read_crc_err;
  logic [47:0]        data_read;
  logic               ncr_timeout;

  sd_cmd_ctrl #(.DELAY_W(DELAY_W), .NCC_DELAY(NCC_DELAY), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_resp_type(cmd_resp_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_status(resp_status), .resp_retries(resp_retries),
    .write_strb(write_strb), .write_no_crc_sig(write_no_crc_sig), .write_bits(write_bits),
    .write_delay(write_delay), .data_towrite(data_towrite),
    .write_data_ack(write_data_ack), .more_data_towrite(more_data_towrite),
    .read_ready(read_ready), .read_crc_err(read_crc_err), .data_read(data_read),
    .ncr_timeout(ncr_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       idx;
    logic [31:0]      arg;
    logic [1:0]       rt;
    logic [2:0]       is_resp;   // per attempt: serializer returns a frame, else NCR timeout
    logic [2:0]       crc;       // per attempt read_crc_err
    logic [2:0][47:0] frame;     // per attempt received frame
    logic             both;      // raise ncr_timeout together with read_ready
    int               hold;      // clks resp_ready stays low once resp_valid is up
    logic [31:0]      exp_w0;
    logic [31:0]      exp_w1;
    int               exp_strobes;
    logic [47:0]      exp_data;
    logic [3:0]       exp_status;
    logic [1:0]       exp_retries;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [2:0] is_resp, input logic [2:0] crc, input logic [47:0] f,
                         input logic [31:0] w0, input logic [31:0] w1, input int strobes,
                         input logic [47:0] d, input logic [3:0] st, input logic [1:0] rr,
                         input int hold, input logic both);
    vec_t v;
    v.idx = idx; v.arg = arg; v.rt = rt; v.is_resp = is_resp; v.crc = crc;
    v.frame[0] = f; v.frame[1] = f; v.frame[2] = f; v.both = both; v.hold = hold;
    v.exp_w0 = w0; v.exp_w1 = w1; v.exp_strobes = strobes;
    v.exp_data = d; v.exp_status = st; v.exp_retries = rr;
    vecs.push_back(v);
  endtask

  // Reference model: walk the attempts as a requester would see them.
  task automatic model(inout vec_t v);
    logic [5:0]  want;
    logic [47:0] f;
    logic        bad, crc_e;
    v.exp_w0 = {2'b01, v.idx, v.arg[31:8]};
    v.exp_w1 = {v.arg[7:0], 24'h0};
    v.exp_data = '0; v.exp_status = '0; v.exp_retries = '0; v.exp_strobes = 0;
    if (v.rt == 2'b11) begin
      v.exp_status = 4'b1000;
      return;
    end
    want = (v.rt == 2'b10) ? 6'h3F : v.idx;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      v.exp_strobes = a + 1;
      v.exp_retries = (a > 3) ? 2'd3 : 2'(a);
      if (v.rt == 2'b00) begin
        v.exp_data = '0; v.exp_status = '0;
        break;
      end
      if (v.is_resp[a]) begin
        f     = v.frame[a];
        bad   = (f[47:46] != 2'b00) || (f[45:40] != want) || ((v.rt == 2'b10) && !f[0]);
        crc_e = (v.rt == 2'b01) && v.crc[a];
        v.exp_data   = f;
        v.exp_status = {1'b0, bad, crc_e, 1'b0};
        if (bad || !crc_e) break;
      end else begin
        v.exp_data   = '0;
        v.exp_status = 4'b0001;
      end
    end
  endtask

  // Acts as requester and serializer for one command, checking everything on the way.
  task automatic exec(input vec_t v);
    int strobes, guard, att, wait_clks;
    bit done;
    strobes = 0;
    done    = 1'b0;
    // Serializer events while idle must be ignored.
    write_data_ack = 1'b1; read_ready = 1'b1; ncr_timeout = 1'b1; data_read = 48'($urandom);
    @(negedge clk);
    write_data_ack = 1'b0; read_ready = 1'b0; ncr_timeout = 1'b0;
    check("idle_ready", 64'(cmd_ready), 64'(1));
    check("idle_no_strb", 64'(write_strb | resp_valid), 64'(0));
    cmd_valid = 1'b1; cmd_index = v.idx; cmd_arg = v.arg; cmd_resp_type = v.rt;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
    cmd_resp_type = 2'($urandom);
    guard = 0;
    while (!done && guard < 200) begin
      guard++;
      if (resp_valid) begin
        done = 1'b1;
      end else if (write_strb) begin
        att = strobes;
        strobes++;
        check("word0_at_strb", 64'(data_towrite), 64'(v.exp_w0));
        @(negedge clk);
        check("strb_one_clk", 64'(write_strb), 64'(0));
        check("word0_held", 64'(data_towrite), 64'(v.exp_w0));
        write_data_ack = 1'b1; more_data_towrite = 1'b1;
        @(negedge clk);
        write_data_ack = 1'b0; more_data_towrite = 1'b0;
        check("word1", 64'(data_towrite), 64'(v.exp_w1));
        write_data_ack = 1'b1;
        @(negedge clk);
        write_data_ack = 1'b0;
        wait_clks = $urandom_range(0, 2);
        repeat (wait_clks) @(negedge clk);
        if (att < 3 && v.is_resp[att]) begin
          read_ready = 1'b1; data_read = v.frame[att]; read_crc_err = v.crc[att];
          ncr_timeout = v.both;
        end else begin
          ncr_timeout = 1'b1;
        end
        @(negedge clk);
        read_ready = 1'b0; read_crc_err = 1'b0; ncr_timeout = 1'b0;
        if (v.rt == 2'b00) begin
          ncr_timeout = 1'b1;
          @(negedge clk);
          ncr_timeout = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("resp_valid_reached", 64'(done), 64'(1));
    check("strobe_count", 64'(strobes), 64'(v.exp_strobes));
    check("resp_data", 64'(resp_data), 64'(v.exp_data));
    check("resp_status", 64'(resp_status), 64'(v.exp_status));
    check("resp_retries", 64'(resp_retries), 64'(v.exp_retries));
    for (int h = 0; h < v.hold; h++) begin
      if (h == 0) begin
        write_data_ack = 1'b1; read_ready = 1'b1; ncr_timeout = 1'b1; data_read = 48'($urandom);
      end
      @(negedge clk);
      write_data_ack = 1'b0; read_ready = 1'b0; ncr_timeout = 1'b0;
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_data", 64'(resp_data), 64'(v.exp_data));
      check("hold_status", 64'(resp_status), 64'(v.exp_status));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("valid_drop", 64'(resp_valid), 64'(0));
    check("ready_again", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rv;
    bit   seen;
    logic [5:0] want;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_resp_type = '0;
    resp_ready = 1'b0; write_data_ack = 1'b0; more_data_towrite = 1'b0;
    read_ready = 1'b0; read_crc_err = 1'b0; data_read = '0; ncr_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_resp_status", 64'(resp_status), 64'(0));
    check("rst_resp_retries", 64'(resp_retries), 64'(0));
    check("rst_write_strb", 64'(write_strb), 64'(0));
    check("rst_data_towrite", 64'(data_towrite), 64'(0));
    check("const_bits", 64'(write_bits), 64'(40));
    check("const_delay", 64'(write_delay), 64'(NCC_DELAY));
    check("const_no_crc", 64'(write_no_crc_sig), 64'(0));
    resetn = 1'b1;
    @(negedge clk);

    //       idx    arg            rt     resp    crc     frame                 w0             w1             n  data                  st       rr hold both
    add_vec(6'd0,  32'h0,         2'b00, 3'b000, 3'b000, 48'h0,                32'h4000_0000, 32'h0,         1, 48'h0,                4'b0000, 0, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b111, 3'b000, 48'h11_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 1, 48'h11_DEAD_BEEF_AB,  4'b0000, 0, 10, 0);
    add_vec(6'd41, 32'h40FF_8000, 2'b10, 3'b111, 3'b111, 48'h3F_80FF_8000_FF,  32'h6940_FF80, 32'h0,         1, 48'h3F_80FF_8000_FF,  4'b0000, 0, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b111, 3'b011, 48'h11_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 3, 48'h11_DEAD_BEEF_AB,  4'b0000, 2, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b111, 3'b111, 48'h11_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 3, 48'h11_DEAD_BEEF_AB,  4'b0010, 2, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b000, 3'b000, 48'h0,                32'h5100_0012, 32'h3400_0000, 3, 48'h0,                4'b0001, 2, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b111, 3'b000, 48'h12_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 1, 48'h12_DEAD_BEEF_AB,  4'b0100, 0, 1,  0);
    add_vec(6'd5,  32'hA5A5_A5A5, 2'b11, 3'b000, 3'b000, 48'h0,                32'h0,         32'h0,         0, 48'h0,                4'b1000, 0, 2,  0);
    add_vec(6'd8,  32'h0000_01AA, 2'b00, 3'b001, 3'b001, 48'h11_DEAD_BEEF_AB,  32'h4800_0001, 32'hAA00_0000, 1, 48'h0,                4'b0000, 0, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b110, 3'b000, 48'h11_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 2, 48'h11_DEAD_BEEF_AB,  4'b0000, 1, 1,  0);
    add_vec(6'd41, 32'h40FF_8000, 2'b10, 3'b111, 3'b000, 48'h3F_80FF_8000_FE,  32'h6940_FF80, 32'h0,         1, 48'h3F_80FF_8000_FE,  4'b0100, 0, 1,  0);
    add_vec(6'd17, 32'h0000_1234, 2'b01, 3'b111, 3'b000, 48'h11_DEAD_BEEF_AB,  32'h5100_0012, 32'h3400_0000, 1, 48'h11_DEAD_BEEF_AB,  4'b0000, 0, 1,  1);
    add_vec(6'd0,  32'h0,         2'b00, 3'b001, 3'b000, 48'h11_DEAD_BEEF_AB,  32'h4000_0000, 32'h0,         1, 48'h0,                4'b0000, 0, 1,  1);
    foreach (vecs[i]) exec(vecs[i]);

    // Reset while the second word is on offer: no result may ever appear.
    cmd_valid = 1'b1; cmd_index = 6'd17; cmd_arg = 32'h0000_1234; cmd_resp_type = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    write_data_ack = 1'b1; more_data_towrite = 1'b1;
    @(negedge clk);
    write_data_ack = 1'b0; more_data_towrite = 1'b0;
    check("mid_word1", 64'(data_towrite), 64'(32'h3400_0000));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_valid", 64'(resp_valid), 64'(0));
    check("mid_rst_towrite", 64'(data_towrite), 64'(0));
    check("mid_rst_status", 64'(resp_status), 64'(0));
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      write_data_ack = c[0]; read_ready = c[1]; ncr_timeout = c[2]; data_read = 48'h11_DEAD_BEEF_AB;
      @(negedge clk);
      if (resp_valid || write_strb || !cmd_ready) seen = 1'b1;
    end
    write_data_ack = 1'b0; read_ready = 1'b0; ncr_timeout = 1'b0;
    check("mid_rst_no_result", 64'(seen), 64'(0));
    exec(vecs[1]);

    for (int n = 0; n < 40; n++) begin
      rv.idx  = 6'($urandom);
      rv.arg  = $urandom;
      rv.rt   = 2'($urandom_range(0, 3));
      rv.both = ($urandom_range(0, 3) == 0);
      rv.hold = $urandom_range(0, 3);
      want    = (rv.rt == 2'b10) ? 6'h3F : rv.idx;
      for (int a = 0; a < 3; a++) begin
        rv.is_resp[a] = ($urandom_range(0, 3) != 0);
        rv.crc[a]     = ($urandom_range(0, 2) == 0);
        rv.frame[a]   = {2'b00,
                         ($urandom_range(0, 7) != 0) ? want : (want ^ 6'($urandom_range(1, 63))),
                         32'($urandom), 7'($urandom), ($urandom_range(0, 9) != 0)};
        if ($urandom_range(0, 15) == 0) rv.frame[a][47:46] = 2'b10;
      end
      model(rv);
      exec(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
